mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter DATA_BASE, default 1024: byte address mapped to SRAM word 0.
REQ-002 Parameter WAIT_CYCLES, default 2, legal range 1..15: cycles each 16-bit SRAM half-access is held.
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  in  1  reset, asynchronous, active-low.
REQ-005 Port: mem_r_en  in  1  load request from the EXE/MEM pipeline register.
REQ-006 Port: mem_w_en  in  1  store request from the EXE/MEM pipeline register.
REQ-007 Port: alu_res  in  32  byte address computed by the execute stage.
REQ-008 Port: val_r_m  in  32  store data, already forwarded by the execute stage.
REQ-009 Port: mem_out  out  32  last completed load data, registered.
REQ-010 Port: ready  out  1  high = access finished or no access pending; low = the pipeline freezes.
REQ-011 Port: sram_addr  out  18  SRAM half-word address.
REQ-012 Port: sram_dq_out  out  16  SRAM write data.
REQ-013 Port: sram_dq_oe  out  1  write-data drive enable.
REQ-014 Port: sram_dq_in  in  16  SRAM read data.
REQ-015 Port: sram_we_n  out  1  SRAM write strobe, active-low.

Function
REQ-016 Word address shall be computed as (alu_res - DATA_BASE) bits [18:2], modulo 2^17; bits [1:0] are ignored, and addresses below DATA_BASE wrap with no error.
REQ-017 Address mapping: lo half = {word,0}, hi half = {word,1}; the lo half holds data bits [15:0] and the hi half holds bits [31:16].
REQ-018 FSM states shall be IDLE, LO, HI and DONE, with a phase counter of 4 bits.
REQ-019 IDLE: a request (mem_r_en or mem_w_en) moves the FSM to LO, latches the operation type, word address and val_r_m, and clears the counter.
REQ-020 LO and HI: each state is held for exactly WAIT_CYCLES cycles, counting 0..WAIT_CYCLES-1. LO then goes to HI; HI then goes to DONE.
REQ-021 DONE: the FSM goes to IDLE unconditionally after one cycle.
REQ-022 ready is combinational: it is 1 in DONE, 1 in IDLE when no request is present, and 0 otherwise. It shall therefore drop in the same cycle a request appears in IDLE.
REQ-023 Latency: a request occupies 2*WAIT_CYCLES+2 cycles, with ready low for the first 2*WAIT_CYCLES+1 cycles. With default parameters this is 6 cycles, ready low for 5.
REQ-024 In DONE the pipeline advances; the still-asserted request in DONE shall not start a new access.
REQ-025 Read: sram_we_n=1 and sram_dq_oe=0 throughout. sram_dq_in shall be captured on the last LO cycle into a lo buffer and on the last HI cycle into mem_out[31:16]. mem_out[15:0] shall be loaded from the lo buffer on the same edge.
REQ-026 Write: sram_dq_oe=1 and sram_we_n=0 for every cycle of LO and HI. sram_dq_out carries latched data [15:0] in LO and [31:16] in HI. mem_out is unchanged.
REQ-027 If mem_r_en and mem_w_en are both high, the access shall be treated as a write.
REQ-028 Outside LO and HI: sram_we_n=1, sram_dq_oe=0, sram_dq_out=0, and sram_addr holds its last value.
REQ-029 Request inputs shall be sampled only in IDLE; changes during LO or HI are ignored.

Reset
REQ-030 While rst=0: the FSM is IDLE, the counter is 0, mem_out=0, the lo buffer=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0 and sram_we_n=1.
REQ-031 Reset asserted mid-access shall abort the access immediately. Any SRAM write in progress is truncated. mem_out and the other registers take their reset values, not partial data.
REQ-032 After reset release, the first request is handled per REQ-019 on the next rising edge.

Verification
REQ-033 Write test: alu_res=1024, val_r_m=0xDEADBEEF, mem_w_en=1. Required response:
- sram_addr=0 with dq_out=0xBEEF and we_n=0 for 2 cycles;
- then sram_addr=1 with dq_out=0xDEAD for 2 cycles;
- ready low for 5 cycles, then high for 1 cycle.
REQ-034 Read test: alu_res=1028, mem_r_en=1, and the SRAM model returns 0x1234 at address 2 and 0xABCD at address 3. Required response: mem_out=0xABCD1234 in DONE; we_n stays 1 throughout.
REQ-035 Idle test: no request for 10 cycles. Required response: ready=1, we_n=1, oe=0 and mem_out unchanged.
REQ-036 Wrap and both-enables test: alu_res=1020 with both enables high. Required response: a write to sram_addr 0x3FFFE then 0x3FFFF.
REQ-037 Reset test: rst pulled low during HI of a read. Required response: immediately IDLE, mem_out=0, ready=1; after release, a fresh read completes correctly.
REQ-038 Parameter test: WAIT_CYCLES=1 with back-to-back reads. Required response: each read takes 4 cycles and ready is high exactly one cycle between reads.

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: turns one 32-bit load/store into two 16-bit SRAM half-accesses
// (lo then hi), freezing the pipeline through the ready output until the access completes.
module mem_stage #(
    parameter logic [31:0] DATA_BASE   = 32'd1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] alu_res,
    input  logic [31:0] val_r_m,
    output logic [31:0] mem_out,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n
);
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [16:0] word_q, word_d;
    logic [31:0] data_q, data_d;
    logic [15:0] lo_buf_q, lo_buf_d;
    logic [31:0] mem_out_q, mem_out_d;
    logic [17:0] addr_q, addr_d;
    logic        req;
    logic [16:0] word_in;
    logic        last;

    assign req     = mem_r_en | mem_w_en;
    // Subtraction wraps modulo 2^32, so addresses below DATA_BASE land at the top of SRAM.
    assign word_in = 17'((alu_res - DATA_BASE) >> 2);
    assign last    = (cnt_q == LAST);

    assign mem_out   = mem_out_q;
    assign sram_addr = addr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_q      <= 1'b0;
            word_q    <= '0;
            data_q    <= '0;
            lo_buf_q  <= '0;
            mem_out_q <= '0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            word_q    <= word_d;
            data_q    <= data_d;
            lo_buf_q  <= lo_buf_d;
            mem_out_q <= mem_out_d;
            addr_q    <= addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        word_d      = word_q;
        data_d      = data_q;
        lo_buf_d    = lo_buf_q;
        mem_out_d   = mem_out_q;
        addr_d      = addr_q;
        ready       = 1'b0;
        sram_we_n   = 1'b1;
        sram_dq_oe  = 1'b0;
        sram_dq_out = '0;

        case (state_q)
            IDLE: begin
                ready = ~req;
                if (req) begin
                    state_d = LO;
                    cnt_d   = '0;
                    wr_d    = mem_w_en;
                    word_d  = word_in;
                    data_d  = val_r_m;
                    addr_d  = {word_in, 1'b0};
                end
            end
            LO: begin
                if (wr_q) begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = data_q[15:0];
                end
                if (last) begin
                    state_d = HI;
                    cnt_d   = '0;
                    addr_d  = {word_q, 1'b1};
                    if (!wr_q) lo_buf_d = sram_dq_in;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HI: begin
                if (wr_q) begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = data_q[31:16];
                end
                if (last) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    if (!wr_q) mem_out_d = {sram_dq_in, lo_buf_q};
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
